// File: rtl/gray_counter_n_pkg.sv
// Shared types and helpers for the Gray counter family.
// Word-level helpers work on a 32-bit container; callers cast to their own width.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_UP,
    ACT_DN
  } gray_act_e;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Terminal value of a w-bit counter: all ones counting up, zero counting down.
  function automatic gray_word_t term_val(input int w, input logic up);
    gray_word_t t;
    t = '0;
    if (up) begin
      for (int i = 0; i < GRAY_MAX_W; i++) begin
        if (i < w) t[i] = 1'b1;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/gray_counter_n_if.sv
// Control and output bundle of gray_counter_n; clock and reset stay plain ports.
interface gray_counter_n_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out_counter;
  logic [WIDTH-1:0] out_bin;
  logic             tc;

  modport master (
    output en, up_dn, load, load_val,
    input  out_counter, out_bin, tc
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output out_counter, out_bin, tc
  );

endinterface

// File: rtl/gray_counter_n_conv.sv
// Combinational binary-to-reflected-Gray converter, WIDTH up to 32 bits.
module gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = WIDTH'(bin2gray(gray_word_t'(i_bin)));

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised synchronous Gray counter with registered Gray and binary views.
// Gray register is fed from the same next-binary value, so it steps one bit at a time.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit SATURATE   = 1'b0,
  parameter bit INVERT_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       set,
  gray_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(term_val(WIDTH, 1'b1));
  localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(term_val(WIDTH, 1'b0));
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_at_term;
  gray_act_e        w_act;

  assign w_at_term = bus.up_dn ? (r_bin == TERM_UP) : (r_bin == TERM_DN);

  always_comb begin
    w_act = ACT_HOLD;
    if (bus.load)      w_act = ACT_LOAD;
    else if (bus.en)   w_act = bus.up_dn ? ACT_UP : ACT_DN;
  end

  // Wrap falls out of modulo arithmetic; saturation just suppresses the step.
  always_comb begin
    w_bin_nxt = r_bin;
    case (w_act)
      ACT_LOAD: w_bin_nxt = bus.load_val;
      ACT_UP:   if (!(SATURATE && w_at_term)) w_bin_nxt = r_bin + ONE;
      ACT_DN:   if (!(SATURATE && w_at_term)) w_bin_nxt = r_bin - ONE;
      default:  w_bin_nxt = r_bin;
    endcase
  end

  gray_conv #(
    .WIDTH (WIDTH)
  ) u_conv (
    .i_bin  (w_bin_nxt),
    .o_gray (w_gray_nxt)
  );

  always_ff @(posedge clk) begin
    if (set) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
    end
  end

  assign bus.out_bin     = r_bin;
  assign bus.out_counter = INVERT_OUT ? ~r_gray : r_gray;
  assign bus.tc          = bus.en & w_at_term;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n across four width/saturate/polarity configurations.
module tb_gray_counter_n;
  import gray_pkg::*;

  bit clk;
  always #5 clk = ~clk;

  logic       set, en, up, load;
  logic [6:0] lv;

  gray_counter_n_if #(.WIDTH(4)) if0 ();
  gray_counter_n_if #(.WIDTH(4)) if1 ();
  gray_counter_n_if #(.WIDTH(7)) if2 ();
  gray_counter_n_if #(.WIDTH(7)) if3 ();

  assign if0.en = en;  assign if0.up_dn = up;  assign if0.load = load;  assign if0.load_val = lv[3:0];
  assign if1.en = en;  assign if1.up_dn = up;  assign if1.load = load;  assign if1.load_val = lv[3:0];
  assign if2.en = en;  assign if2.up_dn = up;  assign if2.load = load;  assign if2.load_val = lv;
  assign if3.en = en;  assign if3.up_dn = up;  assign if3.load = load;  assign if3.load_val = lv;

  gray_counter_n #(.WIDTH(4), .SATURATE(1'b0), .INVERT_OUT(1'b0)) u_dut0 (.clk(clk), .set(set), .bus(if0));
  gray_counter_n #(.WIDTH(4), .SATURATE(1'b1), .INVERT_OUT(1'b0)) u_dut1 (.clk(clk), .set(set), .bus(if1));
  gray_counter_n #(.WIDTH(7), .SATURATE(1'b0), .INVERT_OUT(1'b1)) u_dut2 (.clk(clk), .set(set), .bus(if2));
  gray_counter_n #(.WIDTH(7), .SATURATE(1'b1), .INVERT_OUT(1'b1)) u_dut3 (.clk(clk), .set(set), .bus(if3));

  logic [3:0][7:0] o_bin, o_oc;
  logic [3:0]      o_tc;
  assign o_bin[0] = 8'(if0.out_bin);  assign o_oc[0] = 8'(if0.out_counter);  assign o_tc[0] = if0.tc;
  assign o_bin[1] = 8'(if1.out_bin);  assign o_oc[1] = 8'(if1.out_counter);  assign o_tc[1] = if1.tc;
  assign o_bin[2] = 8'(if2.out_bin);  assign o_oc[2] = 8'(if2.out_counter);  assign o_tc[2] = if2.tc;
  assign o_bin[3] = 8'(if3.out_bin);  assign o_oc[3] = 8'(if3.out_counter);  assign o_tc[3] = if3.tc;

  typedef struct packed {
    logic [3:0][7:0] bin;
    logic [3:0][7:0] oc;
    logic [3:0]      step;
  } st_t;

  st_t        st_q[$];
  logic [3:0] tc_q[$];
  int         m[4];
  int         checks = 0;
  int         errors = 0;
  bit         started = 0;

  function automatic int w_of(int i);   return (i < 2) ? 4 : 7;        endfunction
  function automatic bit sat_of(int i); return (i % 2) == 1;           endfunction
  function automatic bit inv_of(int i); return i >= 2;                 endfunction
  function automatic int top_of(int i); return (1 << w_of(i)) - 1;    endfunction

  // Reference behaviour: plain integer counting over 0..2^w-1.
  function automatic int model_next(int i, int c, bit s, bit ld, int v, bit e, bit u);
    int top = top_of(i);
    if (s)  return 0;
    if (ld) return v & top;
    if (!e) return c;
    if (u)  return (c == top) ? (sat_of(i) ? c : 0) : c + 1;
    return (c == 0) ? (sat_of(i) ? 0 : top) : c - 1;
  endfunction

  function automatic int exp_oc(int i, int c);
    int g = c ^ (c >> 1);
    return inv_of(i) ? (~g & top_of(i)) : g;
  endfunction

  task automatic check(string name, int i, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic dchk(string name, int i, int eb, int eo);
    check({name, "_bin"}, i, int'(o_bin[i]), eb);
    check({name, "_oc"},  i, int'(o_oc[i]),  eo);
  endtask

  task automatic cyc(bit s, bit ld, logic [6:0] v, bit e, bit u);
    st_t        ent;
    logic [3:0] t;
    int         n;
    @(negedge clk);
    set = s; load = ld; lv = v; en = e; up = u;
    for (int i = 0; i < 4; i++) begin
      t[i]        = e && (u ? (m[i] == top_of(i)) : (m[i] == 0));
      n           = model_next(i, m[i], s, ld, int'(v), e, u);
      ent.bin[i]  = 8'(n);
      ent.oc[i]   = 8'(exp_oc(i, n));
      ent.step[i] = !s && !ld && e && (n != m[i]);
      m[i]        = n;
    end
    tc_q.push_back(t);
    st_q.push_back(ent);
  endtask

  // Monitor: outputs are presented every cycle; settled values sampled 2ns after negedge.
  initial begin
    logic [3:0][7:0] prev;
    st_t             ent;
    logic [3:0]      t;
    int              cor;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (tc_q.size() > 0) begin
        t = tc_q.pop_front();
        if (started)
          for (int i = 0; i < 4; i++) check("tc", i, int'(o_tc[i]), int'(t[i]));
      end
      if (st_q.size() > 1) begin
        ent = st_q.pop_front();
        started = 1;
        for (int i = 0; i < 4; i++) begin
          check("bin", i, int'(o_bin[i]), int'(ent.bin[i]));
          check("oc",  i, int'(o_oc[i]),  int'(ent.oc[i]));
          if (ent.step[i]) check("hamming", i, $countones(prev[i] ^ o_oc[i]), 1);
          cor = inv_of(i) ? (~int'(o_oc[i]) & top_of(i)) : int'(o_oc[i]);
          check("gray2bin", i, int'(gray2bin(gray_word_t'(cor))), int'(o_bin[i]));
        end
      end
      prev = o_oc;
    end
  end

  initial begin
    int  seq[17];
    bit  dir;
    seq = '{'h0, 'h1, 'h3, 'h2, 'h6, 'h7, 'h5, 'h4, 'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 'h9, 'h8, 'h0};
    set = 1; en = 0; up = 1; load = 0; lv = '0;
    for (int i = 0; i < 4; i++) m[i] = 0;

    repeat (3) cyc(1, 0, 0, 0, 1);
    @(posedge clk); #1;
    dchk("reset", 0, 0, 0);
    dchk("reset", 2, 0, 'h7F);

    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 0, 1, 1);
      @(posedge clk); #1;
      check("up_seq", 0, int'(o_oc[0]), seq[k+1]);
    end

    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    @(posedge clk); #1;
    dchk("down_wrap", 0, 'hF, 'h8);
    repeat (3) cyc(0, 0, 0, 1, 0);

    cyc(1, 0, 0, 0, 1);
    repeat (15) cyc(0, 0, 0, 1, 1);
    @(posedge clk); #1;
    dchk("sat_top", 1, 'hF, 'h8);
    repeat (5) cyc(0, 0, 0, 1, 1);
    @(posedge clk); #1;
    dchk("sat_hold", 1, 'hF, 'h8);
    cyc(0, 0, 0, 1, 0);
    @(posedge clk); #1;
    dchk("sat_turn", 1, 'hE, 'h9);

    cyc(0, 1, 7'h0A, 1, 1);
    @(posedge clk); #1;
    dchk("load", 0, 'hA, 'hF);
    cyc(0, 0, 0, 1, 1);
    @(posedge clk); #1;
    dchk("load_next", 0, 'hB, 'hE);

    cyc(0, 1, 7'h7F, 1, 1);
    repeat (2) cyc(0, 0, 0, 1, 1);

    cyc(0, 1, 7'h07, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 7'h03, 1, 1);
      @(posedge clk); #1;
      dchk("set_hold", 0, 0, 0);
      dchk("set_hold", 2, 0, 'h7F);
    end

    dir = 1;
    repeat (10000) begin
      if ($urandom_range(0, 31) == 0) dir = ~dir;
      cyc($urandom_range(0, 511) == 0, $urandom_range(0, 31) == 0, 7'($urandom),
          $urandom_range(0, 3) != 0, dir);
    end

    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    @(negedge clk); #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised, fully synchronous Gray-code counter: the successor to the fixed 4-bit ripple counter. It runs on a single clock with width, count direction, load, enable, saturate/wrap mode and output polarity all selectable. Gray and binary views are both registered, so every Gray step changes exactly one bit and downstream logic sees no glitches. It serves as the pointer/sequence source for clock-domain-crossing and position-encoder logic in the counter family.

## Interface
- WIDTH, 4: counter width in bits, ≥2.
- SATURATE, 0: 0 = wrap at terminal value; 1 = hold at terminal value.
- INVERT_OUT, 1: 1 = `out_counter` is the bitwise complement of the Gray state; 0 = true Gray.
- clk  in  1  sole clock; all state updates on the rising edge.
- set  in  1  reset, synchronous, active-high; clears the count.
- en  in  1  count enable.
- up_dn  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  binary value to load.
- out_counter  out  WIDTH  registered Gray state, polarity per INVERT_OUT.
- out_bin  out  WIDTH  registered binary count, true polarity.
- tc  out  1  terminal count: en & (state at terminal for current up_dn).

## Operation
- State: binary register `bin_q`, Gray register `gray_q`. `gray_q` is always bin2gray(`bin_q`). Both are loaded from the same next-binary value in the same edge; `gray_q` is never decoded from combinational logic downstream.
- Per-edge priority: set > load > en > hold.
  - set: `bin_q`=0, `gray_q`=0.
  - load: `bin_q`=load_val, `gray_q`=bin2gray(load_val). en and up_dn are ignored.
  - en & up_dn: increment. Terminal value is 2^WIDTH−1. At terminal, the counter wraps to 0 (SATURATE=0) or holds (SATURATE=1).
  - en & !up_dn: decrement. Terminal value is 0. At terminal, the counter wraps to 2^WIDTH−1 (SATURATE=0) or holds (SATURATE=1).
  - !en: hold.
- Binary arithmetic is modulo 2^WIDTH. The Gray sequence is the standard reflected code: g = b ^ (b>>1).
- out_counter = INVERT_OUT ? ~gray_q : gray_q. out_bin = bin_q.
- tc is combinational from `bin_q`, en and up_dn. It is independent of load and set, and is asserted in the cycle before the wrapping or saturating edge.
- A direction change takes effect on the next enabled edge. No dead cycle.

## Timing
- Reset values: bin_q=0, out_bin=0, out_counter = all-ones (INVERT_OUT=1) or 0 (INVERT_OUT=0). tc = en & !up_dn while in reset-held state.
- Latency: one clock from the sampled control or data to the outputs.
- set held high overrides everything for every cycle it is high. Deassertion mid-count restarts from 0. No partial state survives.
- load and set in the same cycle: set wins.
- load of the terminal value with en high in the same cycle: the load wins. tc reflects the new state on the following cycle.
- SATURATE=1 at terminal with en held: outputs stable and tc stays high every cycle.
- Every non-load, non-reset output transition of out_counter differs in exactly one bit, including wrap (1000↔0000 Gray for WIDTH=4).

## Structure
- Package `gray_pkg`:
  - function `bin2gray(b)`
  - function `gray2bin(g)`, XOR-prefix, used by the bench and by future consumers
  - localparam helper for terminal values
- One sub-module, `gray_conv`: a parametrised combinational bin2gray used for the next-state Gray value. It is instantiated once.
- Counter next-state logic and both registers live in `gray_counter_n`.

## Test plan
- Reset, then 16 enabled up edges (WIDTH=4, INVERT_OUT=0):
  - out_counter steps 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - tc is high only while out_bin=F.
  - every step is single-bit (Hamming distance 1).
- Down count from reset, SATURATE=0:
  - first edge gives out_bin=F, out_counter=8.
  - tc is high at out_bin=0.
- SATURATE=1, up to F, then 5 more enabled edges:
  - out_bin stays F, out_counter stays 8, tc is continuously high.
  - after flipping up_dn=0, the next edge gives E / 9.
- load_val=A with en=1, up_dn=1 in the same cycle:
  - next edge gives out_bin=A, out_counter=F.
  - the following edge gives B / E.
- set asserted at out_bin=7 while load=1 and en=1:
  - next edge gives out_bin=0.
  - out_counter = F with INVERT_OUT=1, 0 with INVERT_OUT=0.
  - holding set for 3 cycles keeps these values.
- Random en/up_dn/load for 10k cycles with WIDTH=7:
  - scoreboard model matches.
  - gray2bin(out_counter, polarity-corrected) == out_bin every cycle.
